ram_io_responder: RTL and testbench
===================================

Name: ram_io_responder

Overview:
Responder end of the byte-wide memory bus that the memory controller drives with addr, wr and dout, and samples on din. It backs the bus with a synchronous byte RAM and a memory-mapped IO window. Writes to the IO window pass through a TX FIFO toward the UART transmitter, which back-pressures via io_buffer_full. Reads from the IO window pop a byte from the UART receiver.

Parameters:
- RAM_ADDR_W, 17, RAM is 2^RAM_ADDR_W bytes, indexed by mem_addr[RAM_ADDR_W-1:0].
- TX_DEPTH, 8, TX FIFO entries; power of 2, at least 4.
- IO_BASE, 32'h0003_0000, start of IO window; IO is selected when mem_addr[17:16]==2'b11.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  in  32  byte address from controller; only [17:0] decoded.
- mem_wr  in  1  1 = write, 0 = read.
- mem_wdata  in  8  write byte (controller dout).
- mem_rdata  out  8  read byte (controller din).
- io_buffer_full  out  1  TX FIFO near-full back-pressure.
- tx_valid  out  1  TX FIFO head valid toward UART.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  UART accepts head this cycle.
- rx_valid  in  1  UART receiver holds a byte.
- rx_data  in  8  received byte.
- rx_pop  out  1  one-cycle pulse; receiver byte consumed.
- sim_halt  out  1  sticky; program wrote the halt register.
- tx_overflow  out  1  sticky; an IO write hit a full FIFO.

Behaviour:
- Reset, asynchronous: mem_rdata=0, FIFO empty, tx_valid=0, io_buffer_full=0, rx_pop=0, sim_halt=0, tx_overflow=0. RAM contents are not reset; they are preloaded by the bench.
- Every cycle is an independent transaction: no request/ack, no idle encoding. A read is any cycle with mem_wr=0.
- RAM read: mem_rdata at edge N+1 = RAM[addr] as presented in cycle N. Read latency is exactly 1 cycle.
- RAM write, mem_wr=1 with a non-IO address: RAM[addr] <= mem_wdata at that edge. mem_rdata holds its previous value.
- Same-address write followed by a read next cycle returns the new byte.
- IO write, offset 0x0 (IO_BASE+0): push mem_wdata into TX FIFO.
  - If the FIFO is full: byte dropped, tx_overflow <= 1.
- IO write, offset 0x4: sim_halt <= 1.
- IO write, other offsets: ignored.
- IO read, offset 0x0:
  - rx_valid=1: mem_rdata <= rx_data and rx_pop pulses that edge.
  - rx_valid=0: mem_rdata <= 0, no pop.
- IO read, offset 0x4: mem_rdata <= {6'b0, rx_valid, io_buffer_full}.
- IO read, other offsets: mem_rdata <= 0.
- Reads never have side effects except the offset-0x0 pop.
- TX FIFO:
  - Occupancy count is 0..TX_DEPTH.
  - tx_valid = (count != 0); tx_data = head byte.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop when non-empty: count unchanged, data order preserved.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted with no overflow.
  - Pointers wrap modulo TX_DEPTH.
- io_buffer_full is registered, = (next_count >= TX_DEPTH-2). The 2-entry headroom covers the controller's one-cycle reaction lag plus an in-flight write.
- Sticky flags clear only on rst.
- Controller drives mem_wr=0, addr=0 when idle. This is a RAM read of address 0 and is harmless.

Decomposition:
- Shared package/definition header: IO_BASE, IO offsets (IO_UART=0x0, IO_HALT=0x4), MEM_READ/MEM_WRITE encodings, BYTE_TYPE width macro.
- Sub-module byte_fifo (parameter DEPTH): push/pop/full/empty/count, asynchronous reset. Used for the TX path.
- RAM array and address decode stay in the top level.

Test Plan:
- Preload RAM[0x100..0x103]=11,22,33,44; present reads of addr 0x100..0x103 on consecutive cycles -> mem_rdata shows 11,22,33,44 one cycle after each address, back-to-back.
- Write 0xA5 to 0x1FFFF, read 0x1FFFF next cycle -> mem_rdata=0xA5 on the following edge. A read of 0x30000-aliased RAM is never performed.
- tx_ready=0; write 0x41..0x48 to 0x30000 (8 writes, TX_DEPTH=8):
  - io_buffer_full rises after the 6th push.
  - 9th write -> tx_overflow=1.
  - Raise tx_ready -> tx_data drains 0x41..0x48 in order, then tx_valid=0.
- FIFO full with tx_ready=1 and an IO write in the same cycle -> no overflow, count stays 8, new byte appears last.
- rx_valid=1, rx_data=0x5A; read 0x30000 -> mem_rdata=0x5A, rx_pop one-cycle pulse. Repeat with rx_valid=0 -> mem_rdata=0, no pulse. Read 0x30004 -> bit1 reflects rx_valid.
- Write any byte to 0x30004 -> sim_halt=1. Assert rst mid-FIFO-drain -> all outputs return to reset values immediately (asynchronous) and the FIFO is empty.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
// ---------------------------------------------------------------------------
// ram_io_responder_pkg
// Shared definitions for the byte-wide memory bus responder: byte type,
// default IO window base, IO register offsets, bus direction encoding and
// the address decoder used by the top level.
// ---------------------------------------------------------------------------
package ram_io_responder_pkg;

    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] byte_t;

    // Default start of the IO window; address bits [17:16] select it.
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Register offsets inside the IO window.
    localparam logic [15:0] IO_UART = 16'h0000;
    localparam logic [15:0] IO_HALT = 16'h0004;

    // Bus direction as driven on mem_wr.
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    // Target of one bus cycle.
    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_IO_UART,
        REGION_IO_HALT,
        REGION_IO_OTHER
    } region_e;

    // Only address bits [17:0] take part in decoding.
    function automatic region_e decode_region(input logic [17:0] addr,
                                              input logic [1:0]  io_sel_bits);
        if (addr[17:16] != io_sel_bits)
            return REGION_RAM;
        else if (addr[15:0] == IO_UART)
            return REGION_IO_UART;
        else if (addr[15:0] == IO_HALT)
            return REGION_IO_HALT;
        else
            return REGION_IO_OTHER;
    endfunction

endpackage

// File: rtl/ram_io_responder_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Byte FIFO with first-word-fall-through head, used for the UART TX path.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is dropped (the caller detects that case from full_o).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_i/wdata_i  write request and byte
//   pop_i           remove head (ignored when empty)
//   rdata_o         head byte
//   empty_o/full_o  current occupancy flags
//   almost_full_o   registered: next occupancy >= AFULL_LEVEL
// ---------------------------------------------------------------------------
module byte_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       almost_full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    byte_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             afull_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CNT_W'(DEPTH));
    assign do_pop        = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push       = push_i && (!full_o || do_pop);
    assign count_d       = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    assign rdata_o       = mem_q[rd_ptr_q];
    assign almost_full_o = afull_q;

    // NOTE: storage is deliberately left out of reset; only pointers and
    // count define which entries are live, and a reset array would cost a
    // reset net per bit for nothing.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (do_push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            afull_q <= (count_d >= CNT_W'(AFULL_LEVEL));
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// ---------------------------------------------------------------------------
// ram_io_responder
// Responder for the controller's byte-wide memory bus. Every cycle is one
// transaction: mem_wr=1 writes, mem_wr=0 reads with one cycle latency.
// Addresses with [17:16]==IO_BASE[17:16] hit the IO window, all others hit
// a synchronous byte RAM indexed by mem_addr[RAM_ADDR_W-1:0].
//
// IO map (offset within window):
//   0x0 write  push byte to TX FIFO (dropped and tx_overflow set when full)
//   0x0 read   pop UART receiver byte, 0 when none is held
//   0x4 write  set sim_halt
//   0x4 read   {6'b0, rx_valid, io_buffer_full}
//   other      writes ignored, reads return 0
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mem_addr_i/mem_wr_i/mem_wdata_i   bus request from controller
//   mem_rdata_o                   registered read byte
//   io_buffer_full_o              TX back-pressure (2 entries of headroom)
//   tx_valid_o/tx_data_o/tx_ready_i   TX FIFO head toward UART
//   rx_valid_i/rx_data_i/rx_pop_o     UART receiver byte and consume pulse
//   sim_halt_o, tx_overflow_o     sticky status flags
// ---------------------------------------------------------------------------
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int          RAM_ADDR_W = 17,
    parameter int          TX_DEPTH   = 8,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_wr_i,
    input  logic [7:0]  mem_wdata_i,
    output logic [7:0]  mem_rdata_o,
    output logic        io_buffer_full_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_pop_o,
    output logic        sim_halt_o,
    output logic        tx_overflow_o
);

    localparam int RAM_BYTES = 1 << RAM_ADDR_W;

    byte_t                 ram_q [RAM_BYTES];
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  unused_addr_bits;

    byte_t   mem_rdata_q, mem_rdata_d;
    logic    sim_halt_q;
    logic    tx_overflow_q;

    region_e region;
    logic    is_write;
    logic    ram_we;
    logic    tx_push;
    logic    halt_wr;
    logic    rx_take;

    logic    tx_empty;
    logic    tx_full;
    logic    tx_afull;
    logic    tx_pop;
    logic    tx_drop;

    assign ram_addr         = mem_addr_i[RAM_ADDR_W-1:0];
    assign unused_addr_bits = &{1'b0, mem_addr_i[31:18]};

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        is_write    = (mem_op_e'(mem_wr_i) == MEM_WRITE);
        region      = decode_region(mem_addr_i[17:0], IO_BASE[17:16]);
        ram_we      = 1'b0;
        tx_push     = 1'b0;
        halt_wr     = 1'b0;
        rx_take     = 1'b0;
        mem_rdata_d = mem_rdata_q;    // writes leave the read byte untouched
        case (region)
            REGION_RAM: begin
                if (is_write) ram_we      = 1'b1;
                else          mem_rdata_d = ram_q[ram_addr];
            end
            REGION_IO_UART: begin
                if (is_write) begin
                    tx_push = 1'b1;
                end else begin
                    rx_take     = rx_valid_i;
                    mem_rdata_d = rx_valid_i ? rx_data_i : '0;
                end
            end
            REGION_IO_HALT: begin
                if (is_write) halt_wr     = 1'b1;
                else          mem_rdata_d = {6'b0, rx_valid_i, tx_afull};
            end
            default: begin
                if (!is_write) mem_rdata_d = '0;
            end
        endcase
    end

    // The receiver consumes its byte on the same edge that captures it.
    assign rx_pop_o = rx_take && !rst;

    always_ff @(posedge clk) begin
        if (ram_we)
            ram_q[ram_addr] <= mem_wdata_i;
    end

    assign tx_valid_o = !tx_empty;
    assign tx_pop     = tx_valid_o && tx_ready_i;
    assign tx_drop    = tx_push && tx_full && !tx_pop;

    byte_fifo #(
        .DEPTH       (TX_DEPTH),
        .AFULL_LEVEL (TX_DEPTH - 2)
    ) u_tx_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (tx_push),
        .wdata_i       (mem_wdata_i),
        .pop_i         (tx_pop),
        .rdata_o       (tx_data_o),
        .empty_o       (tx_empty),
        .full_o        (tx_full),
        .almost_full_o (tx_afull)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata_q   <= '0;
            sim_halt_q    <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else begin
            mem_rdata_q <= mem_rdata_d;
            if (halt_wr)
                sim_halt_q <= 1'b1;
            if (tx_drop)
                tx_overflow_q <= 1'b1;
        end
    end

    assign mem_rdata_o      = mem_rdata_q;
    assign io_buffer_full_o = tx_afull;
    assign sim_halt_o       = sim_halt_q;
    assign tx_overflow_o    = tx_overflow_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// ---------------------------------------------------------------------------
// tb_ram_io_responder
// Directed bench for ram_io_responder: inputs change 1 time unit after the
// rising edge, registered outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_ram_io_responder;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        sim_halt;
    logic        tx_overflow;

    int n_vec  = 0;
    int n_miss = 0;

    ram_io_responder dut (
        .clk              (clk),
        .rst              (rst),
        .mem_addr_i       (mem_addr),
        .mem_wr_i         (mem_wr),
        .mem_wdata_i      (mem_wdata),
        .mem_rdata_o      (mem_rdata),
        .io_buffer_full_o (io_buffer_full),
        .tx_valid_o       (tx_valid),
        .tx_data_o        (tx_data),
        .tx_ready_i       (tx_ready),
        .rx_valid_i       (rx_valid),
        .rx_data_i        (rx_data),
        .rx_pop_o         (rx_pop),
        .sim_halt_o       (sim_halt),
        .tx_overflow_o    (tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr    = wr;
        mem_addr  = a;
        mem_wdata = d;
        step();
    endtask

    task automatic idle();
        bus(1'b0, 32'h0, 8'h00);
    endtask

    task automatic apply_reset();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = 32'h0;
        rst      = 1'b1;
        #2;
        rst      = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst      = 1'b1;
        tx_ready = 1'b0;
        // An IO read with a held byte would pop if reset did not gate it.
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        mem_wr   = 1'b0;
        mem_addr = 32'h0003_0000;
        mem_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        obs = {mem_rdata, tx_valid, io_buffer_full, rx_pop, sim_halt, tx_overflow};
        n_vec++;
        if (obs !== 13'h0) begin
            n_miss++;
            $display("FAIL reset_outputs: got %h want 0000", obs);
        end
        rx_valid = 1'b0;
        mem_addr = 32'h0;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic test_ram();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4; i++)
            bus(1'b1, 32'h100 + i, exp_b[i]);
        // Back-to-back reads, each byte visible one edge after its address.
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, 32'h100 + i, 8'h00);
            n_vec++;
            if (mem_rdata !== exp_b[i]) begin
                n_miss++;
                $display("FAIL ram_read_%0d: got %h want %h", i, mem_rdata, exp_b[i]);
            end
        end
        bus(1'b1, 32'h0001_FFFF, 8'hA5);
        n_vec++;
        if (mem_rdata !== 8'h44) begin
            n_miss++;
            $display("FAIL ram_write_holds_rdata: got %h want 44", mem_rdata);
        end
        bus(1'b0, 32'h0001_FFFF, 8'h00);
        n_vec++;
        if (mem_rdata !== 8'hA5) begin
            n_miss++;
            $display("FAIL ram_write_then_read: got %h want a5", mem_rdata);
        end
    endtask

    task automatic test_tx_fill_drain();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            bus(1'b1, 32'h0003_0000, 8'h41 + 8'(k));
            n_vec++;
            if (io_buffer_full !== (k >= 5)) begin
                n_miss++;
                $display("FAIL io_full_after_push_%0d: got %b want %b", k + 1, io_buffer_full, (k >= 5));
            end
        end
        n_vec++;
        if (tx_overflow !== 1'b0) begin
            n_miss++;
            $display("FAIL no_overflow_at_8: got %b want 0", tx_overflow);
        end
        bus(1'b0, 32'h0003_0004, 8'h00);
        n_vec++;
        if (mem_rdata !== 8'h01) begin
            n_miss++;
            $display("FAIL status_full_fifo: got %h want 01", mem_rdata);
        end
        bus(1'b1, 32'h0003_0000, 8'h49);
        n_vec++;
        if (tx_overflow !== 1'b1) begin
            n_miss++;
            $display("FAIL overflow_on_9th: got %b want 1", tx_overflow);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h41 + 8'(i)) begin
                n_miss++;
                $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'h41 + 8'(i));
            end
            idle();
        end
        n_vec++;
        if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
            n_miss++;
            $display("FAIL drained_empty: got v=%b full=%b want v=0 full=0", tx_valid, io_buffer_full);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int k = 0; k < 8; k++)
            bus(1'b1, 32'h0003_0000, 8'h50 + 8'(k));
        tx_ready = 1'b1;
        bus(1'b1, 32'h0003_0000, 8'h58);
        n_vec++;
        if (tx_overflow !== 1'b0 || io_buffer_full !== 1'b1) begin
            n_miss++;
            $display("FAIL full_push_pop_flags: got ovf=%b full=%b want ovf=0 full=1", tx_overflow, io_buffer_full);
        end
        // Eight entries remain (0x51..0x58), then empty.
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h51 + 8'(i)) begin
                n_miss++;
                $display("FAIL full_push_pop_drain_%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'h51 + 8'(i));
            end
            idle();
        end
        n_vec++;
        if (tx_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL full_push_pop_empty: got v=%b want 0", tx_valid);
        end
    endtask

    task automatic test_rx();
        apply_reset();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        mem_wr   = 1'b0;
        mem_addr = 32'h0003_0000;
        #1;
        n_vec++;
        if (rx_pop !== 1'b1) begin
            n_miss++;
            $display("FAIL rx_pop_pulse: got %b want 1", rx_pop);
        end
        step();
        n_vec++;
        if (mem_rdata !== 8'h5A) begin
            n_miss++;
            $display("FAIL rx_read_data: got %h want 5a", mem_rdata);
        end
        rx_valid = 1'b0;
        #1;
        n_vec++;
        if (rx_pop !== 1'b0) begin
            n_miss++;
            $display("FAIL rx_no_pop_when_empty: got %b want 0", rx_pop);
        end
        step();
        n_vec++;
        if (mem_rdata !== 8'h00) begin
            n_miss++;
            $display("FAIL rx_read_empty: got %h want 00", mem_rdata);
        end
        rx_valid = 1'b1;
        mem_addr = 32'h0003_0004;
        #1;
        n_vec++;
        if (rx_pop !== 1'b0) begin
            n_miss++;
            $display("FAIL status_read_no_pop: got %b want 0", rx_pop);
        end
        step();
        n_vec++;
        if (mem_rdata !== 8'h02) begin
            n_miss++;
            $display("FAIL status_rx_valid: got %h want 02", mem_rdata);
        end
        bus(1'b0, 32'h0003_0008, 8'h00);
        n_vec++;
        if (mem_rdata !== 8'h00) begin
            n_miss++;
            $display("FAIL io_other_read: got %h want 00", mem_rdata);
        end
        rx_valid = 1'b0;
        bus(1'b1, 32'h0003_0008, 8'h99);
        n_vec++;
        if (tx_valid !== 1'b0 || sim_halt !== 1'b0) begin
            n_miss++;
            $display("FAIL io_other_write_ignored: got v=%b halt=%b want v=0 halt=0", tx_valid, sim_halt);
        end
    endtask

    task automatic test_halt_reset();
        logic [12:0] obs;
        apply_reset();
        bus(1'b1, 32'h0003_0000, 8'h61);
        bus(1'b1, 32'h0003_0000, 8'h62);
        bus(1'b1, 32'h0003_0000, 8'h63);
        bus(1'b1, 32'h0003_0004, 8'h3C);
        n_vec++;
        if (sim_halt !== 1'b1) begin
            n_miss++;
            $display("FAIL halt_set: got %b want 1", sim_halt);
        end
        bus(1'b0, 32'h100, 8'h00);
        tx_ready = 1'b1;
        idle();
        n_vec++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h62) begin
            n_miss++;
            $display("FAIL mid_drain_head: got v=%b d=%h want v=1 d=62", tx_valid, tx_data);
        end
        // Reset lands between edges; outputs must clear without a clock.
        rx_valid = 1'b1;
        rx_data  = 8'h12;
        mem_addr = 32'h0003_0000;
        #2;
        rst = 1'b1;
        #1;
        obs = {mem_rdata, tx_valid, io_buffer_full, rx_pop, sim_halt, tx_overflow};
        n_vec++;
        if (obs !== 13'h0) begin
            n_miss++;
            $display("FAIL async_reset_outputs: got %h want 0000", obs);
        end
        rx_valid = 1'b0;
        mem_addr = 32'h0;
        #1;
        rst = 1'b0;
        step();
        n_vec++;
        if (tx_valid !== 1'b0 || sim_halt !== 1'b0) begin
            n_miss++;
            $display("FAIL fifo_empty_after_reset: got v=%b halt=%b want v=0 halt=0", tx_valid, sim_halt);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_addr  = 32'h0;
        mem_wr    = 1'b0;
        mem_wdata = 8'h00;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;

        test_reset();
        test_ram();
        test_tx_fill_drain();
        test_full_push_pop();
        test_rx();
        test_halt_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
